scan_mux: RTL and testbench

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux.sv | 146 ++++++++++++++
 tb/tb_scan_mux.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual select and a dwell-timed auto-scan
// over an enable mask; o/cur_sel/valid/wrap are all flop outputs.
module scan_mux #(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int SEL_W = 3,
    parameter int DWELL = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*WIDTH-1:0] I,
    input  logic [SEL_W-1:0]    s,
    input  logic                mode,
    input  logic [CH-1:0]       en_mask,
    input  logic                hold,
    output logic [WIDTH-1:0]    o,
    output logic [SEL_W-1:0]    cur_sel,
    output logic                valid,
    output logic                wrap
);
    localparam int NSEL = 1 << SEL_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {MANUAL, SCAN, EMPTY} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [WIDTH-1:0] o_reg, o_next;
    logic             valid_reg, valid_next;
    logic             wrap_reg, wrap_next;

    logic [WIDTH-1:0] ch_data [NSEL];
    logic [NSEL-1:0]  mask_pad;
    logic [SEL_W-1:0] adv_idx;
    logic             adv_wrap;
    logic             cur_enabled;

    // Pad channel data and mask out to the full select range so that select
    // values at or above CH read as a disabled, all-zero channel.
    genvar gi;
    generate
        for (gi = 0; gi < NSEL; gi++) begin : g_pad
            if (gi < CH) begin : g_live
                assign ch_data[gi]  = I[gi*WIDTH +: WIDTH];
                assign mask_pad[gi] = en_mask[gi];
            end else begin : g_dead
                assign ch_data[gi]  = '0;
                assign mask_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign cur_enabled = mask_pad[sel_reg];

    // Next enabled channel strictly above sel_reg, modulo CH. Scanning from the
    // farthest candidate to the nearest lets the nearest hit win. An
    // out-of-range sel_reg searches from channel 0.
    always_comb begin
        int base;
        int cand;
        adv_idx = sel_reg;
        base = (int'(sel_reg) < CH) ? int'(sel_reg) : CH - 1;
        for (int k = CH; k >= 1; k--) begin
            cand = base + k;
            if (cand >= CH) begin
                cand = cand - CH;
            end
            if (mask_pad[cand[SEL_W-1:0]]) begin
                adv_idx = cand[SEL_W-1:0];
            end
        end
    end

    assign adv_wrap = (adv_idx <= sel_reg);

    always_comb begin
        state_next = MANUAL;
        if (mode) begin
            state_next = (en_mask == '0) ? EMPTY : SCAN;
        end

        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        wrap_next  = 1'b0;
        valid_next = 1'b0;
        o_next     = '0;

        case (state_next)
            MANUAL: begin
                sel_next   = s;
                cnt_next   = '0;
                valid_next = (int'(s) < CH);
                o_next     = ch_data[s];
            end
            EMPTY: begin
                cnt_next = '0;
            end
            default: begin
                valid_next = 1'b1;
                if (!cur_enabled) begin
                    // A disabled current channel forces an advance, even under hold.
                    sel_next  = adv_idx;
                    cnt_next  = '0;
                    wrap_next = adv_wrap;
                end else if (state_reg != SCAN) begin
                    cnt_next = '0;
                end else if (hold) begin
                    cnt_next = cnt_reg;
                end else if (cnt_reg == CNT_LAST) begin
                    sel_next  = adv_idx;
                    cnt_next  = '0;
                    wrap_next = adv_wrap;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
                o_next = ch_data[sel_next];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= MANUAL;
            cnt_reg   <= '0;
            sel_reg   <= '0;
            o_reg     <= '0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            o_reg     <= o_next;
            valid_reg <= valid_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign o       = o_reg;
    assign cur_sel = sel_reg;
    assign valid   = valid_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: two instances (8x8 DWELL=4, 5x16 DWELL=2)
// compared each cycle against a rule-level reference model.
module tb_scan_mux;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8 = 1'b1, mode8 = 1'b0, hold8 = 1'b0;
    logic [63:0] I8 = '0;
    logic [2:0]  s8 = '0;
    logic [7:0]  mask8 = '0;
    logic [7:0]  o8;
    logic [2:0]  cur_sel8;
    logic        valid8, wrap8;

    logic        rst5 = 1'b1, mode5 = 1'b0, hold5 = 1'b0;
    logic [79:0] I5 = '0;
    logic [2:0]  s5 = '0;
    logic [4:0]  mask5 = '0;
    logic [15:0] o5;
    logic [2:0]  cur_sel5;
    logic        valid5, wrap5;

    scan_mux #(.WIDTH(8), .CH(8), .SEL_W(3), .DWELL(4)) dut (
        .clk(clk), .rst(rst8), .I(I8), .s(s8), .mode(mode8), .en_mask(mask8),
        .hold(hold8), .o(o8), .cur_sel(cur_sel8), .valid(valid8), .wrap(wrap8)
    );

    scan_mux #(.WIDTH(16), .CH(5), .SEL_W(3), .DWELL(2)) dut5 (
        .clk(clk), .rst(rst5), .I(I5), .s(s5), .mode(mode5), .en_mask(mask5),
        .hold(hold5), .o(o5), .cur_sel(cur_sel5), .valid(valid5), .wrap(wrap5)
    );

    typedef struct {
        int          sel;
        int          cnt;
        bit          scanning;
        logic [15:0] o;
        bit          valid;
        bit          wrap;
    } mstate_t;

    mstate_t m8, m5;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    function automatic logic [15:0] chan(logic [255:0] din, int k, int width);
        logic [255:0] t;
        t = din >> (k * width);
        return (width == 16) ? t[15:0] : {8'h00, t[7:0]};
    endfunction

    // Reference behaviour: what each edge does, stated directly from the rules.
    function automatic mstate_t model_next(mstate_t st, int ch, int dwell, int width,
                                           logic [255:0] din, int sel_in, bit mode_in,
                                           logic [15:0] mask, bit hold_in, bit rst_in);
        mstate_t n;
        bit advance;
        n = st;
        n.wrap = 0;
        advance = 0;
        if (rst_in) begin
            n.sel = 0; n.cnt = 0; n.scanning = 0; n.o = '0; n.valid = 0;
            return n;
        end
        if (!mode_in) begin
            n.sel = sel_in; n.cnt = 0; n.scanning = 0;
            n.valid = (sel_in < ch);
            n.o = (sel_in < ch) ? chan(din, sel_in, width) : 16'h0;
        end else if (mask == 16'h0) begin
            n.cnt = 0; n.scanning = 0; n.valid = 0; n.o = '0;
        end else begin
            if (!(st.sel < ch && mask[st.sel])) advance = 1;
            else if (!st.scanning) n.cnt = 0;
            else if (hold_in) n.cnt = st.cnt;
            else if (st.cnt == dwell - 1) advance = 1;
            else n.cnt = st.cnt + 1;
            if (advance) begin
                int start;
                start = (st.sel < ch) ? st.sel : -1;
                for (int k = 1; k <= ch; k++) begin
                    if (mask[(start + k) % ch]) begin
                        n.sel = (start + k) % ch;
                        break;
                    end
                end
                n.cnt = 0;
                n.wrap = (n.sel <= st.sel);
            end
            n.scanning = 1; n.valid = 1;
            n.o = chan(din, n.sel, width);
        end
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        m8 = model_next(m8, 8, 4, 8, {192'b0, I8}, int'(s8), mode8, {8'b0, mask8}, hold8, rst8);
        m5 = model_next(m5, 5, 2, 16, {176'b0, I5}, int'(s5), mode5, {11'b0, mask5}, hold5, rst5);
        #1;
        cyc++;
        $display("txn cyc=%0d dut8: o=%h sel=%0d v=%b w=%b | dut5: o=%h sel=%0d v=%b w=%b",
                 cyc, o8, cur_sel8, valid8, wrap8, o5, cur_sel5, valid5, wrap5);
    endtask

    task automatic test_reset();
        rst8 = 1; rst5 = 1; mode8 = 1; mask8 = 8'hFF; s8 = 3'd5; I8 = {8{8'hA5}};
        mode5 = 0; s5 = 3'd3;
        tick();
        checks++;
        if ({o8, cur_sel8, valid8, wrap8} !== 13'h0) begin
            errors++;
            $display("FAIL reset8: got o=%h sel=%0d v=%b w=%b, expected all zero", o8, cur_sel8, valid8, wrap8);
        end
        checks++;
        if ({o5, cur_sel5, valid5, wrap5} !== 21'h0) begin
            errors++;
            $display("FAIL reset5: got o=%h sel=%0d v=%b w=%b, expected all zero", o5, cur_sel5, valid5, wrap5);
        end
        rst8 = 0; rst5 = 0; mode8 = 0;
    endtask

    task automatic test_manual_sweep();
        for (int k = 0; k < 8; k++) I8[k*8 +: 8] = 8'h10 + 8'(k);
        mode8 = 0; mask8 = $urandom; hold8 = $urandom;
        for (int k = 0; k < 8; k++) begin
            s8 = 3'(k);
            tick();
            checks++;
            if (o8 !== 8'h10 + 8'(k) || valid8 !== 1'b1 || cur_sel8 !== 3'(k)) begin
                errors++;
                $display("FAIL manual_sweep s=%0d: got o=%h v=%b sel=%0d, expected o=%h v=1 sel=%0d",
                         k, o8, valid8, cur_sel8, 8'h10 + 8'(k), k);
            end
        end
    endtask

    task automatic test_full_scan();
        int wraps;
        wraps = 0;
        rst8 = 1; tick(); rst8 = 0;
        mode8 = 1; mask8 = 8'hFF; hold8 = 0;
        for (int c = 0; c < 64; c++) begin
            I8 = {$urandom, $urandom};
            tick();
            if (wrap8) wraps++;
            checks++;
            if ({o8, cur_sel8, valid8, wrap8} !== {m8.o[7:0], 3'(m8.sel), m8.valid, m8.wrap}) begin
                errors++;
                $display("FAIL full_scan cyc %0d: got o=%h sel=%0d v=%b w=%b, expected o=%h sel=%0d v=%b w=%b",
                         c, o8, cur_sel8, valid8, wrap8, m8.o[7:0], m8.sel, m8.valid, m8.wrap);
            end
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL full_scan_wraps: got %0d wrap pulses, expected 1", wraps);
        end
    endtask

    task automatic test_sparse();
        bit seen;
        seen = 0;
        rst8 = 1; tick(); rst8 = 0;
        mode8 = 1; mask8 = 8'b1000_0101; hold8 = 0;
        for (int c = 0; c < 24 && !seen; c++) begin
            tick();
            checks++;
            if ({o8, cur_sel8, valid8, wrap8} !== {m8.o[7:0], 3'(m8.sel), m8.valid, m8.wrap}) begin
                errors++;
                $display("FAIL sparse cyc %0d: got o=%h sel=%0d v=%b w=%b, expected o=%h sel=%0d v=%b w=%b",
                         c, o8, cur_sel8, valid8, wrap8, m8.o[7:0], m8.sel, m8.valid, m8.wrap);
            end
            if (cur_sel8 == 3'd2) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sparse_reach2: got sel=%0d after budget, expected to reach 2", cur_sel8);
        end
        mask8 = 8'b1000_0001;
        tick();
        checks++;
        if (cur_sel8 !== 3'd7 || wrap8 !== 1'b0) begin
            errors++;
            $display("FAIL sparse_clear2: got sel=%0d w=%b, expected sel=7 w=0", cur_sel8, wrap8);
        end
        for (int c = 0; c < 12; c++) begin
            tick();
            checks++;
            if ({o8, cur_sel8, valid8, wrap8} !== {m8.o[7:0], 3'(m8.sel), m8.valid, m8.wrap}) begin
                errors++;
                $display("FAIL sparse_tail cyc %0d: got sel=%0d w=%b, expected sel=%0d w=%b",
                         c, cur_sel8, wrap8, m8.sel, m8.wrap);
            end
        end
    endtask

    task automatic test_hold_empty();
        logic [2:0] held;
        mask8 = 8'hFF; hold8 = 0;
        tick(); tick();
        held = cur_sel8;
        hold8 = 1;
        for (int c = 0; c < 10; c++) begin
            I8 = {$urandom, $urandom};
            tick();
            checks++;
            if (cur_sel8 !== held || o8 !== m8.o[7:0] || {valid8, wrap8} !== {m8.valid, m8.wrap}) begin
                errors++;
                $display("FAIL hold cyc %0d: got sel=%0d o=%h, expected sel=%0d o=%h", c, cur_sel8, o8, held, m8.o[7:0]);
            end
        end
        hold8 = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({o8, cur_sel8, valid8, wrap8} !== {m8.o[7:0], 3'(m8.sel), m8.valid, m8.wrap}) begin
                errors++;
                $display("FAIL hold_release cyc %0d: got sel=%0d o=%h, expected sel=%0d o=%h", c, cur_sel8, o8, m8.sel, m8.o[7:0]);
            end
        end
        mask8 = 8'h00;
        tick();
        checks++;
        if (valid8 !== 1'b0 || o8 !== 8'h00 || wrap8 !== 1'b0 || cur_sel8 !== 3'(m8.sel)) begin
            errors++;
            $display("FAIL empty: got o=%h v=%b w=%b sel=%0d, expected o=00 v=0 w=0 sel=%0d", o8, valid8, wrap8, cur_sel8, m8.sel);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        seen = 0;
        rst8 = 1; tick(); rst8 = 0;
        mode8 = 1; mask8 = 8'hFF; hold8 = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (cur_sel8 == 3'd5) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rst_mid_reach5: got sel=%0d after budget, expected to reach 5", cur_sel8);
        end
        tick(); tick();
        rst8 = 1;
        tick();
        rst8 = 0;
        checks++;
        if ({o8, cur_sel8, valid8, wrap8} !== 13'h0) begin
            errors++;
            $display("FAIL rst_mid: got o=%h sel=%0d v=%b w=%b, expected all zero", o8, cur_sel8, valid8, wrap8);
        end
        tick();
        checks++;
        if (cur_sel8 !== 3'd0 || valid8 !== 1'b1) begin
            errors++;
            $display("FAIL rst_restart: got sel=%0d v=%b, expected sel=0 v=1", cur_sel8, valid8);
        end
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (cur_sel8 !== 3'd1) begin
            errors++;
            $display("FAIL rst_dwell: got sel=%0d after 4 more edges, expected 1", cur_sel8);
        end
    endtask

    task automatic test_param();
        rst5 = 1; tick(); rst5 = 0;
        for (int k = 0; k < 5; k++) I5[k*16 +: 16] = 16'h1000 + 16'(k);
        mode5 = 0; s5 = 3'd6;
        tick();
        checks++;
        if (valid5 !== 1'b0 || o5 !== 16'h0 || cur_sel5 !== 3'd6) begin
            errors++;
            $display("FAIL param_manual_oob: got o=%h v=%b sel=%0d, expected o=0000 v=0 sel=6", o5, valid5, cur_sel5);
        end
        mode5 = 1; mask5 = 5'h1F; hold5 = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if (cur_sel5 >= 3'd5 || {o5, cur_sel5, valid5, wrap5} !== {m5.o, 3'(m5.sel), m5.valid, m5.wrap}) begin
                errors++;
                $display("FAIL param_scan cyc %0d: got o=%h sel=%0d v=%b w=%b, expected o=%h sel=%0d v=%b w=%b",
                         c, o5, cur_sel5, valid5, wrap5, m5.o, m5.sel, m5.valid, m5.wrap);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            I8 = {$urandom, $urandom};
            I5 = {$urandom, $urandom, $urandom};
            s8 = 3'($urandom); s5 = 3'($urandom);
            hold8 = ($urandom_range(0, 3) == 0); hold5 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) mode8 = ~mode8;
            if ($urandom_range(0, 15) == 0) mode5 = ~mode5;
            if ($urandom_range(0, 7) == 0) mask8 = ($urandom_range(0, 5) == 0) ? 8'h0 : 8'($urandom);
            if ($urandom_range(0, 7) == 0) mask5 = ($urandom_range(0, 5) == 0) ? 5'h0 : 5'($urandom);
            rst8 = ($urandom_range(0, 49) == 0); rst5 = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if ({o8, cur_sel8, valid8, wrap8} !== {m8.o[7:0], 3'(m8.sel), m8.valid, m8.wrap}) begin
                errors++;
                $display("FAIL random8 cyc %0d: got o=%h sel=%0d v=%b w=%b, expected o=%h sel=%0d v=%b w=%b",
                         c, o8, cur_sel8, valid8, wrap8, m8.o[7:0], m8.sel, m8.valid, m8.wrap);
            end
            checks++;
            if ({o5, cur_sel5, valid5, wrap5} !== {m5.o, 3'(m5.sel), m5.valid, m5.wrap}) begin
                errors++;
                $display("FAIL random5 cyc %0d: got o=%h sel=%0d v=%b w=%b, expected o=%h sel=%0d v=%b w=%b",
                         c, o5, cur_sel5, valid5, wrap5, m5.o, m5.sel, m5.valid, m5.wrap);
            end
        end
        rst8 = 0; rst5 = 0;
    endtask

    initial begin
        m8 = '{sel: 0, cnt: 0, scanning: 0, o: 16'h0, valid: 0, wrap: 0};
        m5 = m8;
        test_reset();
        test_manual_sweep();
        test_full_scan();
        test_sparse();
        test_hold_empty();
        test_reset_mid_scan();
        test_param();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
